// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    localparam logic LevelIdle  = 1'b1;
    localparam logic LevelStart = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == CntMax)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign bit_end = (cnt_q == CntMax);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one word per frame and sends start, data LSB-first,
// optional even parity (FIFO_UART_TX_PARITY_EN) and stop.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

    tx_state_t             state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [BitW-1:0]       bit_cnt_q;
    logic                  bit_end;
    logic                  timer_clear;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q;
`endif

    // Restart the baud counter so the start bit gets a full period.
    assign timer_clear = (state_q == StLoad);
    assign shift_next  = shift_q >> 1;
    assign busy        = (state_q != StIdle);
    assign frame_done  = (state_q == StStop) && bit_end;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx         <= LevelIdle;
            fifo_rd_en <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            fifo_rd_en <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx_enable && !fifo_empty) begin
                        state_q    <= StFetch;
                        fifo_rd_en <= 1'b1;
                    end
                end
                StFetch: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    shift_q   <= fifo_dout;
                    bit_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_q  <= ^fifo_dout;
`endif
                    state_q   <= StStart;
                    tx        <= LevelStart;
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        tx      <= shift_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q <= shift_next;
                        if (bit_cnt_q == LastBit) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            state_q <= StParity;
                            tx      <= parity_q;
`else
                            state_q <= StStop;
                            tx      <= LevelIdle;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                            tx        <= shift_next[0];
                        end
                    end
                end
                StParity: begin
`ifdef FIFO_UART_TX_PARITY_EN
                    if (bit_end) begin
                        state_q <= StStop;
                        tx      <= LevelIdle;
                    end
`else
                    state_q <= StIdle;
                    tx      <= LevelIdle;
`endif
                end
                StStop: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        tx      <= LevelIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx      <= LevelIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a behavioural FIFO and a frame-level line model.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_CYC = (DW + 2 + PAR) * CPB;
    localparam int START_LIMIT = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_enable = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'h00;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int last_rd_cyc = 0;
    int start_cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_enable (tx_enable),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model with one-cycle registered read data.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
            if (!fifo_empty) begin
                fifo_dout <= mem[rd_ptr % 256];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level at cycle i of a frame carrying w.
    function automatic logic model_bit(input logic [7:0] w, input int i);
        int b;
        b = i / CPB;
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (PAR != 0 && b == DW + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    // Counts idle-high cycles until the start bit appears.
    task automatic wait_start(input string tag, output int gap);
        gap = 0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < START_LIMIT) begin
            gap++;
            @(negedge clk);
        end
        start_cyc = cyc;
        check({tag, "_start_seen"}, 32'(gap < START_LIMIT), 32'd1);
    endtask

    task automatic check_frame(input logic [7:0] w, input string tag, output int gap);
        wait_start(tag, gap);
        if (gap >= START_LIMIT) return;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_tx"}, 32'(tx), 32'(model_bit(w, i)));
            check({tag, "_frame_done"}, 32'(frame_done), 32'(i == FRAME_CYC - 1));
            check({tag, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    initial begin
        int g;
        int g2;
        int r0;
        logic [7:0] words [4];
        logic [7:0] a;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame
        tx_enable = 1'b1;
        r0 = rd_cnt;
        push(8'hA5);
        check_frame(8'hA5, "single", g);
        check("single_pop_to_start", 32'(start_cyc - last_rd_cyc), 32'd2);
        check("single_pops", 32'(rd_cnt - r0), 32'd1);
        @(negedge clk);
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_tx_after", 32'(tx), 32'd1);

        // Back-to-back
        r0 = rd_cnt;
        push(8'h00);
        push(8'hFF);
        check_frame(8'h00, "b2b0", g);
        check_frame(8'hFF, "b2b1", g);
        check("b2b_gap", 32'(g), 32'd3);
        check("b2b_pops", 32'(rd_cnt - r0), 32'd2);
        check("b2b_empty", 32'(fifo_empty), 32'd1);

        // Random words back-to-back
        for (int k = 0; k < 4; k++) begin
            words[k] = 8'($urandom);
            push(words[k]);
        end
        for (int k = 0; k < 4; k++) begin
            check_frame(words[k], "rand", g);
            if (k > 0) check("rand_gap", 32'(g), 32'd3);
        end

        // Empty FIFO
        repeat (100) begin
            @(negedge clk);
            check("empty_tx", 32'(tx), 32'd1);
            check("empty_rd_en", 32'(fifo_rd_en), 32'd0);
            check("empty_busy", 32'(busy), 32'd0);
        end

        // Enable gating
        tx_enable = 1'b0;
        a = 8'($urandom);
        r0 = rd_cnt;
        push(a);
        repeat (50) begin
            @(negedge clk);
            check("gate_tx", 32'(tx), 32'd1);
        end
        check("gate_pops", 32'(rd_cnt - r0), 32'd0);
        check("gate_busy", 32'(busy), 32'd0);
        tx_enable = 1'b1;
        check_frame(a, "gate_release", g);

        // Enable dropped mid-frame
        tx_enable = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        push(a);
        push(b);
        r0 = rd_cnt;
        tx_enable = 1'b1;
        fork
            check_frame(a, "drop", g2);
            begin
                repeat (20) @(negedge clk);
                tx_enable = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        check("drop_pops", 32'(rd_cnt - r0), 32'd1);
        check("drop_left", 32'(wr_ptr - rd_ptr), 32'd1);
        check("drop_busy", 32'(busy), 32'd0);
        tx_enable = 1'b1;
        check_frame(b, "drop_resume", g);

        // Reset mid-frame, during data bit 3 (forced low so the async return to high is visible)
        a = 8'($urandom) & 8'hF7;
        b = 8'($urandom);
        r0 = rd_cnt;
        push(a);
        push(b);
        wait_start("rstmid", g);
        repeat (4 + 3 * 4 + 1) @(negedge clk);
        check("rstmid_pre_tx", 32'(tx), 32'd0);
        check("rstmid_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_tx", 32'(tx), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(b, "rstmid_next", g);
        check("rstmid_pops", 32'(rd_cnt - r0), 32'd2);
        check("rstmid_empty", 32'(fifo_empty), 32'd1);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity frames
        push(8'h07);
        push(8'h03);
        check_frame(8'h07, "par07", g);
        check_frame(8'h03, "par03", g);
        check("par_gap", 32'(g), 32'd3);
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
